// File: rtl/microsoc_bus_pkg.sv
// Shared types and helpers for the core data-port interconnect.
// Field layout of the req/gnt/rvalid data-port protocol.
package microsoc_bus_pkg;

  localparam int DFLT_TARGETS = 2;
  localparam int TGT_IDX_W = $clog2(DFLT_TARGETS + 1);

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

  typedef struct packed {
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;
  } bus_rsp_t;

  function automatic int tgt_idx_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/data_bus_interconnect_fifo.sv
// bus_resp_fifo: in-order queue of target indices
// for granted requests that still await a response.
module bus_resp_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/data_bus_interconnect.sv
// 1-master / N-target data-port interconnect with in-order responses.
// Optional decode-error log: define MICROSOC_DECERR_LOG_EN.
module data_bus_interconnect
  import microsoc_bus_pkg::*;
#(
  parameter int NUM_TARGETS     = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [NUM_TARGETS*ADDR_W-1:0] TARGET_BASE =
    {32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_TARGETS*ADDR_W-1:0] TARGET_MASK =
    {32'hFFFF_F000, 32'hFFFF_0000}
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          m_req_i,
  output logic                          m_gnt_o,
  output logic                          m_rvalid_o,
  input  logic                          m_we_i,
  input  logic [DATA_W/8-1:0]           m_be_i,
  input  logic [ADDR_W-1:0]             m_addr_i,
  input  logic [DATA_W-1:0]             m_wdata_i,
  output logic [DATA_W-1:0]             m_rdata_o,
  output logic                          m_err_o,
  output logic [NUM_TARGETS-1:0]        s_req_o,
  input  logic [NUM_TARGETS-1:0]        s_gnt_i,
  input  logic [NUM_TARGETS-1:0]        s_rvalid_i,
  input  logic [NUM_TARGETS-1:0]        s_err_i,
  input  logic [NUM_TARGETS*DATA_W-1:0] s_rdata_i,
  output logic                          s_we_o,
  output logic [DATA_W/8-1:0]           s_be_o,
  output logic [ADDR_W-1:0]             s_addr_o,
  output logic [DATA_W-1:0]             s_wdata_o
`ifdef MICROSOC_DECERR_LOG_EN
  ,
  output logic                          err_valid_o,
  output logic [ADDR_W-1:0]             err_addr_o,
  output logic                          err_we_o,
  input  logic                          err_clr_i
`endif
);

  localparam int TW = tgt_idx_w(NUM_TARGETS);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [TW-1:0] DECERR = TW'(NUM_TARGETS);

  logic [TW-1:0] sel;
  logic [TW-1:0] last_tgt;
  logic [TW-1:0] head;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          allowed;
  logic          sel_gnt;
  logic          hs;
  logic          decerr_pend;
  logic [NUM_TARGETS-1:0] rsp_ok;

  // Descending scan so the lowest matching index is the last writer.
  always_comb begin
    sel = DECERR;
    for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
      if ((m_addr_i & TARGET_MASK[i*ADDR_W +: ADDR_W]) ==
          TARGET_BASE[i*ADDR_W +: ADDR_W])
        sel = TW'(i);
    end
  end

  assign allowed = m_req_i && !full &&
                   (count == '0 || sel == last_tgt);

  always_comb begin
    s_req_o = '0;
    sel_gnt = 1'b0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (sel == TW'(i)) begin
        s_req_o[i] = allowed;
        sel_gnt    = s_gnt_i[i];
      end
    end
  end

  assign m_gnt_o = allowed && (sel == DECERR || sel_gnt);
  assign hs      = m_req_i && m_gnt_o;

  bus_resp_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (TW),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (hs),
    .pop   (m_rvalid_o),
    .din   (sel),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    m_rvalid_o = 1'b0;
    m_err_o    = 1'b0;
    m_rdata_o  = '0;
    rsp_ok     = '0;
    if (!empty) begin
      if (head == DECERR) begin
        m_rvalid_o = decerr_pend;
        m_err_o    = decerr_pend;
      end else begin
        for (int i = 0; i < NUM_TARGETS; i++) begin
          if (head == TW'(i)) begin
            rsp_ok[i] = 1'b1;
            if (s_rvalid_i[i]) begin
              m_rvalid_o = 1'b1;
              m_err_o    = s_err_i[i];
              m_rdata_o  = s_rdata_i[i*DATA_W +: DATA_W];
            end
          end
        end
      end
    end
  end

  // A decode error answers on the cycle right after its grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_tgt    <= '0;
      decerr_pend <= 1'b0;
    end else begin
      decerr_pend <= hs && (sel == DECERR);
      if (hs) last_tgt <= sel;
    end
  end

  assign s_we_o    = m_we_i;
  assign s_be_o    = m_be_i;
  assign s_addr_o  = m_addr_i;
  assign s_wdata_o = m_wdata_i;

  a_rsp_in_order: assert property (
    @(posedge clk) disable iff (rst)
    (s_rvalid_i & ~rsp_ok) == '0
  );

`ifdef MICROSOC_DECERR_LOG_EN
  logic dec_hs;
  assign dec_hs = hs && (sel == DECERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_valid_o <= 1'b0;
      err_addr_o  <= '0;
      err_we_o    <= 1'b0;
    end else if (dec_hs && (!err_valid_o || err_clr_i)) begin
      err_valid_o <= 1'b1;
      err_addr_o  <= m_addr_i;
      err_we_o    <= m_we_i;
    end else if (err_clr_i) begin
      err_valid_o <= 1'b0;
    end
  end
`endif

endmodule
